// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and a start/busy handshake.
// Define MDU_MACC_EN to add madd/maddu/msub/msubu (ops 7-10); otherwise those ops decode as none.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    // Handshake: start is sampled only while busy=0; an accepted multi-cycle op keeps
    // busy high for exactly N cycles, then done pulses for one cycle with HI/LO updated.
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
    localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;

    logic               is_mul, is_div;
    logic               signed_op, a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, res;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, uq, ur, quo, rem;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MACC_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    // Signed variants are exactly the odd opcodes among the multi-cycle ops.
    always_comb begin
        signed_op = op_q[0];
        a_neg     = signed_op & a_q[WIDTH-1];
        b_neg     = signed_op & b_q[WIDTH-1];
        ext_a     = {{WIDTH{a_neg}}, a_q};
        ext_b     = {{WIDTH{b_neg}}, b_q};
        prod      = ext_a * ext_b;

        mag_a = a_neg ? -a_q : a_q;
        mag_b = b_neg ? -b_q : b_q;
        div_b = (b_q == '0) ? ONE : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quo   = (a_neg ^ b_neg) ? -uq : uq;
        rem   = a_neg ? -ur : ur;
        if (b_q == '0) begin
            quo = '1;
            rem = a_q;
        end else if (signed_op && (a_q == MOST_NEG) && (b_q == '1)) begin
            quo = a_q;
            rem = '0;
        end

        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU:   res = {rem, quo};
`ifdef MDU_MACC_EN
            OP_MADD, OP_MADDU: res = {HI, LO} + prod;
            OP_MSUB, OP_MSUBU: res = {HI, LO} - prod;
`endif
            default:           res = {HI, LO};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            op_q  <= op;
                            a_q   <= A;
                            b_q   <= B;
                            cnt   <= is_div ? DIV_N : MUL_N;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 6'd1) begin
                        {HI, LO} <= res;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the EX stage. Signed/unsigned multiply and divide run over a configurable number of cycles behind a start/busy handshake while the pipeline stalls on `busy`. Direct HI/LO writes are supported, plus optional multiply-accumulate.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 8.
- `MUL_CYCLES`, 5: busy cycles for multiply-class ops; range 1..63.
- `DIV_CYCLES`, 10: busy cycles for divide ops; range 1..63.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 none.
- `A`  in  WIDTH  operand rs.
- `B`  in  WIDTH  operand rt.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse, new HI/LO visible.
- `HI`  out  WIDTH  high product / remainder.
- `LO`  out  WIDTH  low product / quotient.

## Operation
- Reset values: `busy`=0, `done`=0, `HI`=0, `LO`=0; internal counter 0, latched operands 0.
- States: IDLE, RUN. IDLE + `start` + multi-cycle op (1-4, or 7-10 when enabled) latches op, A, B, loads counter with MUL_CYCLES or DIV_CYCLES, goes to RUN.
- RUN: counter decrements each cycle; on the cycle the counter equals 1, HI/LO are written, `done` asserts next cycle, and the unit returns to IDLE.
- mthi/mtlo in IDLE with `start`: HI (or LO) ← A at that edge; no busy, no done.
- `start` while `busy`=1 is ignored entirely, including mthi/mtlo; op none / undefined with `start` is a no-op.
- mult: {HI,LO} ← signed A × signed B (2·WIDTH result). multu: unsigned.
- div: LO ← signed quotient truncated toward zero, HI ← remainder with sign of dividend. divu: unsigned.
- Divide by zero (both div/divu): LO ← all ones, HI ← A. Signed overflow (A = −2^(WIDTH−1), B = −1): LO ← A, HI ← 0.
- madd/maddu: {HI,LO} ← {HI,LO} + product; msub/msubu: {HI,LO} ← {HI,LO} − product. Modulo 2^(2·WIDTH) wrap, no flags. Accumulator value is the HI/LO at completion time.
- Operands are latched at start; changes on A/B during RUN have no effect.
- HI/LO hold their previous values throughout RUN; no partial results are visible.

## Timing
- Start sampled at edge E0 → `busy`=1 from E0 to E0+N (N = MUL_CYCLES or DIV_CYCLES), i.e. exactly N cycles high.
- HI/LO updated at edge E0+N; `done`=1 and `busy`=0 in the cycle following E0+N.
- A new start is accepted in the same cycle that `done` is high (back-to-back, zero bubble).
- mthi/mtlo: HI/LO visible one cycle after the sampling edge.
- `reset` mid-RUN: in-flight result discarded, all outputs return to reset values at that edge, no `done`.
- `reset` and `start` together: reset wins.
- Outputs are registered; no combinational path from inputs to `busy`/`done`/HI/LO.

## Configuration
- `MDU_MACC_EN` defined: ops 7-10 (madd, maddu, msub, msubu) are implemented as described above, using MUL_CYCLES latency.
- Not defined: ops 7-10 are decoded as none; `start` with them leaves `busy` low and HI/LO unchanged, and no accumulator logic is synthesised.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` pulses once.
- divu A=100, B=7 → after 10 busy cycles LO=14, HI=2. div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div A=5, B=0 → LO=0xFFFFFFFF, HI=5. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1234 issued during a multu busy window → ignored; afterwards product only. Then mtlo 0xABCD in IDLE → LO=0xABCD next cycle, `busy` never rises.
- Start multu, assert `reset` at busy cycle 3 → next cycle busy=0, HI=LO=0, no `done`. Back-to-back: start asserted in the `done` cycle → accepted.
- With `MDU_MACC_EN`: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0. Without the macro, same stimulus → `busy` stays 0 and HI/LO are unchanged.
